// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage register and its control FSM.
// State encodings are fixed so debug taps and checkers can decode them directly.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // RISC-V "addi x0,x0,0", used to build NOP-shaped flush values.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  function automatic logic [1:0] beats_held(input pipe_state_e s);
    case (s)
      ST_BUSY: beats_held = 2'd1;
      ST_FULL: beats_held = 2'd2;
      default: beats_held = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_fsm.sv
// Control path of the pipeline stage: occupancy state, accept/dequeue decode and
// load enables for the main and skid payload registers.
module pipe_skid_fsm
  import pipe_pkg::*;
#(
  parameter bit SKID = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic        out_ready_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic        load_main_o,
  output logic        main_from_skid_o,
  output logic        load_skid_o,
  output logic        clear_o,
  output pipe_state_e state_o
);

  // Handshake: a beat moves across a port on a rising edge only when both valid
  // and ready are high in the preceding cycle; valid never waits on ready.

  pipe_state_e state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        acc, deq;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign state_o     = state_q;

  // rdy_q is low through reset, so in_ready rises only after the first edge.
  generate
    if (SKID) begin : g_ready_reg
      assign in_ready_o = rdy_q & ~stall_i;
    end else begin : g_ready_comb
      assign in_ready_o = rdy_q & (~out_valid_o | out_ready_i) & ~stall_i;
    end
  endgenerate

  // A beat offered during flush is dropped even when in_ready is high.
  assign acc = in_valid_i & in_ready_o & ~flush_i;
  assign deq = out_valid_o & out_ready_i & ~stall_i & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (!stall_i) begin
      case (state_q)
        ST_EMPTY: if (acc) state_d = ST_BUSY;
        ST_BUSY: begin
          if (acc && !deq)      state_d = SKID ? ST_FULL : ST_BUSY;
          else if (!acc && deq) state_d = ST_EMPTY;
        end
        ST_FULL:  if (deq) state_d = ST_BUSY;
        default:  state_d = ST_EMPTY;
      endcase
    end
    rdy_d = (state_d != ST_FULL);
  end

  always_comb begin
    load_main_o      = 1'b0;
    main_from_skid_o = 1'b0;
    load_skid_o      = 1'b0;
    clear_o          = flush_i;
    if (!flush_i && !stall_i) begin
      case (state_q)
        ST_EMPTY: load_main_o = acc;
        ST_BUSY: begin
          load_main_o = acc & deq;
          load_skid_o = acc & ~deq;
        end
        ST_FULL: begin
          load_main_o      = deq;
          main_from_skid_o = deq;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// two-entry skid buffer (registered in_ready), synchronous stall and flush.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 96,
  parameter logic [DATA_W-1:0] RST_VAL   = '0,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter bit                SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output pipe_state_e       dbg_state
);

  logic              load_main, main_from_skid, load_skid, clear;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;

  pipe_skid_fsm #(
    .SKID (SKID)
  ) u_fsm (
    .clk              (clk),
    .rst_n            (reset_n),
    .stall_i          (stall),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .out_ready_i      (out_ready),
    .in_ready_o       (in_ready),
    .out_valid_o      (out_valid),
    .load_main_o      (load_main),
    .main_from_skid_o (main_from_skid),
    .load_skid_o      (load_skid),
    .clear_o          (clear),
    .state_o          (dbg_state)
  );

  // main_q is not loaded on a plain dequeue, so an empty stage shows the last beat.
  always_comb begin
    main_d = main_q;
    if (clear)          main_d = FLUSH_VAL;
    else if (load_main) main_d = main_from_skid ? skid_q : in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) main_q <= RST_VAL;
    else          main_q <= main_d;
  end

  generate
    if (SKID) begin : g_skid
      logic [DATA_W-1:0] skid_d;

      always_comb begin
        skid_d = skid_q;
        if (clear)          skid_d = '0;
        else if (load_skid) skid_d = in_data;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) skid_q <= '0;
        else          skid_q <= skid_d;
      end
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 and a SKID=0 instance side by side, each
// compared against a queue-based model of a capacity-limited FIFO stage.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int W = 96;
  localparam logic [W-1:0] RST_V   = 96'hDEAD_BEEF_0000_0000_0000_0001;
  localparam logic [W-1:0] FLUSH_V = {RV_NOP, 64'h0};

  logic         clk, reset_n, stall, flush;
  logic         iv1, ir1, ov1, or1, iv0, ir0, ov0, or0;
  logic [W-1:0] id1, od1, id0, od0;
  pipe_state_e  dbg1, dbg0;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: one queue of held beats per instance.
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] last1, last0;
  bit           rdy_ok;
  bit           er1, er0, obr1, obr0;

  pipe_stage_skid #(.DATA_W(W), .RST_VAL(RST_V), .FLUSH_VAL(FLUSH_V), .SKID(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .dbg_state(dbg1)
  );

  pipe_stage_skid #(.DATA_W(W), .RST_VAL(RST_V), .FLUSH_VAL(FLUSH_V), .SKID(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .dbg_state(dbg0)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model ----------------
  task automatic model_reset();
    exp_q1.delete();
    exp_q0.delete();
    last1  = RST_V;
    last0  = RST_V;
    rdy_ok = 1'b0;
  endtask

  function automatic bit exp_ready(input int held, input bit skid, input bit ordy, input bit st);
    if (!rdy_ok || st) return 1'b0;
    if (skid) return held < 2;
    return (held == 0) || ordy;
  endfunction

  function automatic logic [W-1:0] exp_data1();
    return (exp_q1.size() != 0) ? exp_q1[0] : last1;
  endfunction

  function automatic logic [W-1:0] exp_data0();
    return (exp_q0.size() != 0) ? exp_q0[0] : last0;
  endfunction

  function automatic logic [W-1:0] rand_beat();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive at negedge, sample in_ready before the edge, advance the model.
  task automatic cycle(input bit v1, input logic [W-1:0] d1, input bit r1,
                       input bit v0, input logic [W-1:0] d0, input bit r0,
                       input bit st, input bit fl);
    bit acc, deq;
    @(negedge clk);
    iv1 = v1; id1 = d1; or1 = r1;
    iv0 = v0; id0 = d0; or0 = r0;
    stall = st; flush = fl;
    #1;
    obr1 = ir1;
    obr0 = ir0;
    er1  = exp_ready(exp_q1.size(), 1'b1, r1, st);
    er0  = exp_ready(exp_q0.size(), 1'b0, r0, st);
    @(posedge clk);
    if (fl) begin
      exp_q1.delete(); last1 = FLUSH_V;
      exp_q0.delete(); last0 = FLUSH_V;
    end else if (!st) begin
      deq = (exp_q1.size() != 0) && r1;
      acc = v1 && er1;
      if (deq) last1 = exp_q1.pop_front();
      if (acc) exp_q1.push_back(d1);
      deq = (exp_q0.size() != 0) && r0;
      acc = v0 && er0;
      if (deq) last0 = exp_q0.pop_front();
      if (acc) exp_q0.push_back(d0);
    end
    if (reset_n) rdy_ok = 1'b1;
    #1;
  endtask

  task automatic idle1(input bit r1);
    cycle(1'b0, '0, r1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if (ov1 !== 1'b0 || od1 !== RST_V) begin
      n_err++; $display("FAIL por_outputs: valid=%0b data=%h, required 0 / %h", ov1, od1, RST_V);
    end
    n_checks++;
    if (ir1 !== 1'b0 || ir0 !== 1'b0) begin
      n_err++; $display("FAIL por_in_ready: got %0b/%0b, required 0/0", ir1, ir0);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    idle1(1'b0);
    n_checks++;
    if (ir1 !== 1'b1 || ir0 !== 1'b1) begin
      n_err++; $display("FAIL post_reset_ready: got %0b/%0b, required 1/1", ir1, ir0);
    end
    // Fill to two beats, then reset asynchronously between edges.
    cycle(1'b1, W'(32'h5A), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(32'h5B), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dbg1 !== ST_FULL || ir1 !== 1'b0) begin
      n_err++; $display("FAIL reset_prefill: state=%0d ready=%0b, required 2 / 0", dbg1, ir1);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (ov1 !== 1'b0 || od1 !== RST_V || ir1 !== 1'b0) begin
      n_err++; $display("FAIL async_reset: valid=%0b data=%h ready=%0b, required 0 / %h / 0",
                        ov1, od1, ir1, RST_V);
    end
    model_reset();
    @(posedge clk); #2;
    reset_n = 1'b1;
    idle1(1'b0);
    n_checks++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || od1 !== RST_V) begin
      n_err++; $display("FAIL reset_release: ready=%0b valid=%0b data=%h, required 1 / 0 / %h",
                        ir1, ov1, od1, RST_V);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, W'(i), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obr1 !== 1'b1 || ov1 !== 1'b1 || od1 !== W'(i)) begin
        n_err++; $display("FAIL stream_beat%0d: ready=%0b valid=%0b data=%h, required 1 / 1 / %0h",
                          i, obr1, ov1, od1, i);
      end
    end
    idle1(1'b1);
    n_checks++;
    if (ov1 !== 1'b0 || od1 !== W'(8)) begin
      n_err++; $display("FAIL stream_drain: valid=%0b data=%h, required 0 / 8", ov1, od1);
    end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, W'(32'hA), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(32'hB), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obr1 !== 1'b1 || dbg1 !== ST_FULL || od1 !== W'(32'hA)) begin
      n_err++; $display("FAIL bp_full: ready=%0b state=%0d data=%h, required 1 / 2 / a",
                        obr1, dbg1, od1);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, W'(32'hC), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obr1 !== 1'b0 || od1 !== W'(32'hA) || ov1 !== 1'b1) begin
        n_err++; $display("FAIL bp_hold%0d: ready=%0b valid=%0b data=%h, required 0 / 1 / a",
                          k, obr1, ov1, od1);
      end
    end
    cycle(1'b1, W'(32'hC), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obr1 !== 1'b0 || od1 !== W'(32'hB)) begin
      n_err++; $display("FAIL bp_release1: ready=%0b data=%h, required 0 / b", obr1, od1);
    end
    cycle(1'b1, W'(32'hC), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obr1 !== 1'b1 || od1 !== W'(32'hC) || ov1 !== 1'b1) begin
      n_err++; $display("FAIL bp_release2: ready=%0b valid=%0b data=%h, required 1 / 1 / c",
                        obr1, ov1, od1);
    end
    idle1(1'b1);
    n_checks++;
    if (ov1 !== 1'b0) begin
      n_err++; $display("FAIL bp_drain: valid=%0b, required 0", ov1);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, W'(32'hA), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(32'hB), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(32'hC), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ov1 !== 1'b0 || od1 !== FLUSH_V || dbg1 !== ST_EMPTY) begin
      n_err++; $display("FAIL flush_clear: valid=%0b data=%h state=%0d, required 0 / %h / 0",
                        ov1, od1, dbg1, FLUSH_V);
    end
    idle1(1'b1);
    n_checks++;
    if (ov1 !== 1'b0 || od1 !== FLUSH_V) begin
      n_err++; $display("FAIL flush_no_c: valid=%0b data=%h, required 0 / %h", ov1, od1, FLUSH_V);
    end
    cycle(1'b1, W'(32'hD), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ov1 !== 1'b1 || od1 !== W'(32'hD)) begin
      n_err++; $display("FAIL flush_recover: valid=%0b data=%h, required 1 / d", ov1, od1);
    end
    // Flush wins over a simultaneous stall.
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ov1 !== 1'b0 || od1 !== FLUSH_V) begin
      n_err++; $display("FAIL flush_over_stall: valid=%0b data=%h, required 0 / %h", ov1, od1, FLUSH_V);
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, W'(32'hE1), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, W'(32'hE2), 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obr1 !== 1'b0 || obr0 !== 1'b0 || ov1 !== 1'b1 || od1 !== W'(32'hE1)) begin
        n_err++; $display("FAIL stall_hold%0d: ready=%0b/%0b valid=%0b data=%h, required 0/0 / 1 / e1",
                          k, obr1, obr0, ov1, od1);
      end
    end
    cycle(1'b1, W'(32'hE2), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obr1 !== 1'b1 || ov1 !== 1'b1 || od1 !== W'(32'hE2)) begin
      n_err++; $display("FAIL stall_resume: ready=%0b valid=%0b data=%h, required 1 / 1 / e2",
                        obr1, ov1, od1);
    end
    idle1(1'b1);
    n_checks++;
    if (ov1 !== 1'b0 || od1 !== W'(32'hE2)) begin
      n_err++; $display("FAIL stall_drain: valid=%0b data=%h, required 0 / e2", ov1, od1);
    end
  endtask

  task automatic test_skid0();
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, W'(32'h10 + i), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obr0 !== 1'b1 || ov0 !== 1'b1 || od0 !== W'(32'h10 + i)) begin
        n_err++; $display("FAIL s0_stream%0d: ready=%0b valid=%0b data=%h, required 1 / 1 / %0h",
                          i, obr0, ov0, od0, 32'h10 + i);
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, W'(32'hA), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, W'(32'hB), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obr0 !== 1'b0 || ov0 !== 1'b1 || od0 !== W'(32'hA)) begin
      n_err++; $display("FAIL s0_backpressure: ready=%0b valid=%0b data=%h, required 0 / 1 / a",
                        obr0, ov0, od0);
    end
    cycle(1'b0, '0, 1'b0, 1'b1, W'(32'hB), 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obr0 !== 1'b1 || od0 !== W'(32'hB)) begin
      n_err++; $display("FAIL s0_ready_follows: ready=%0b data=%h, required 1 / b", obr0, od0);
    end
    cycle(1'b0, '0, 1'b0, 1'b1, W'(32'hC), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ov0 !== 1'b0 || od0 !== W'(32'hC)) begin
      n_err++; $display("FAIL s0_drain: valid=%0b data=%h, required 0 / c", ov0, od0);
    end
  endtask

  task automatic test_random();
    bit           pv1, pv0, st, fl, r1, r0;
    logic [W-1:0] pd1, pd0;
    pv1 = 1'b0; pv0 = 1'b0;
    pd1 = rand_beat(); pd0 = rand_beat();
    for (int n = 0; n < 400; n++) begin
      if (!pv1) begin pv1 = ($urandom_range(0, 3) != 0); pd1 = rand_beat(); end
      if (!pv0) begin pv0 = ($urandom_range(0, 3) != 0); pd0 = rand_beat(); end
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 29) == 0);
      r1 = ($urandom_range(0, 2) != 0);
      r0 = ($urandom_range(0, 2) != 0);
      cycle(pv1, pd1, r1, pv0, pd0, r0, st, fl);
      n_checks++;
      if (obr1 !== er1 || obr0 !== er0) begin
        n_err++; $display("FAIL rnd_ready@%0d: got %0b/%0b, required %0b/%0b", n, obr1, obr0, er1, er0);
      end
      n_checks++;
      if (ov1 !== (exp_q1.size() != 0) || od1 !== exp_data1()) begin
        n_err++; $display("FAIL rnd_out1@%0d: valid=%0b data=%h, required %0b / %h",
                          n, ov1, od1, exp_q1.size() != 0, exp_data1());
      end
      n_checks++;
      if (ov0 !== (exp_q0.size() != 0) || od0 !== exp_data0()) begin
        n_err++; $display("FAIL rnd_out0@%0d: valid=%0b data=%h, required %0b / %h",
                          n, ov0, od0, exp_q0.size() != 0, exp_data0());
      end
      n_checks++;
      if (beats_held(dbg1) !== 2'(exp_q1.size())) begin
        n_err++; $display("FAIL rnd_state@%0d: state=%0d holds, required %0d", n, dbg1, exp_q1.size());
      end
      if (fl || (pv1 && er1)) pv1 = 1'b0;
      if (fl || (pv0 && er0)) pv0 = 1'b0;
    end
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset_n = 1'b0;
    stall = 1'b0; flush = 1'b0;
    iv1 = 1'b0; id1 = '0; or1 = 1'b0;
    iv0 = 1'b0; id0 = '0; or0 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall();
    test_skid0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
